// File: rtl/mux_dir_dato.sv
// Multiplexes PicoBlaze command/date bytes onto the RTC's shared DIR_DATO bus
// and captures read-back bytes into the IN_* registers, one byte per cont_32 period.
module mux_dir_dato #(
  parameter logic [7:0] CMD_PORT = 8'h10,
  parameter logic [4:0] CAP_CNT  = 5'd24
) (
  input  logic       reloj,
  input  logic       resetM,
  input  logic [7:0] Inicie,
  input  logic [7:0] Mod_S,
  input  logic [7:0] OUT_diaf,
  input  logic [7:0] OUT_mesf,
  input  logic [7:0] OUT_anof,
  input  logic [7:0] OUT_segh,
  input  logic [7:0] OUT_minh,
  input  logic [7:0] OUT_horah,
  input  logic       en_01,
  input  logic [7:0] out_port,
  input  logic [7:0] port_id,
  input  logic [4:0] cont_32,
  input  logic       enable_cont_32,
  input  logic [4:0] cont17,
  input  logic       LE,
  input  logic       sync,
  output logic [7:0] IN_diaf,
  output logic [7:0] IN_mesf,
  output logic [7:0] IN_anof,
  output logic [7:0] IN_segh,
  output logic [7:0] IN_minh,
  output logic [7:0] IN_horah,
  output logic [7:0] IN_segcr,
  output logic [7:0] IN_mincr,
  output logic [7:0] IN_horacr,
  output logic [3:0] Selec_Demux_DDw,
  output logic       READ,
  output logic [3:0] Selec_Mux_DDw,
  inout  wire  [7:0] DIR_DATO
);

  localparam logic [7:0] CMD_INIT  = 8'h00;
  localparam logic [7:0] CMD_SEG   = 8'h01;
  localparam logic [7:0] CMD_BURST = 8'h02;
  localparam logic [7:0] CMD_MOD   = 8'h03;

  logic [7:0]      cmd_q, cmd_d;
  logic            busy_q, busy_d;
  // Capture registers: 0 segh, 1 minh, 2 horah, 3 diaf, 4 mesf, 5 anof, 6 segcr, 7 mincr, 8 horacr
  logic [8:0][7:0] in_q, in_d;

  logic       active, burst, data_phase, read_now;
  logic [7:0] slot_addr, dato_out;
  logic [3:0] src_code, dmx_code, mux_sel, demux_sel;

  // Counters are zeroed externally on sync; nothing here depends on it.
  logic unused_sync;
  assign unused_sync = sync;

  // Slot decode: which address, write source and capture target belong to this byte.
  always_comb begin
    active    = 1'b0;
    burst     = 1'b0;
    slot_addr = 8'h00;
    src_code  = 4'hF;
    dmx_code  = 4'h0;
    if (busy_q) begin
      case (cmd_q)
        CMD_INIT: begin active = 1'b1; slot_addr = 8'h00; src_code = 4'h1; end
        CMD_MOD:  begin active = 1'b1; slot_addr = 8'h01; src_code = 4'h2; end
        CMD_SEG:  begin active = 1'b1; slot_addr = 8'h21; src_code = 4'h3; dmx_code = 4'h1; end
        CMD_BURST: begin
          active = 1'b1;
          burst  = 1'b1;
          case (cont17)
            5'd0: begin slot_addr = 8'h21; src_code = 4'h3; dmx_code = 4'h1; end
            5'd1: begin slot_addr = 8'h22; src_code = 4'h4; dmx_code = 4'h2; end
            5'd2: begin slot_addr = 8'h23; src_code = 4'h5; dmx_code = 4'h3; end
            5'd3: begin slot_addr = 8'h24; src_code = 4'h6; dmx_code = 4'h4; end
            5'd4: begin slot_addr = 8'h25; src_code = 4'h7; dmx_code = 4'h5; end
            5'd5: begin slot_addr = 8'h26; src_code = 4'h8; dmx_code = 4'h6; end
            5'd6: begin slot_addr = 8'h41; src_code = 4'h9; dmx_code = 4'h7; end
            5'd7: begin slot_addr = 8'h42; src_code = 4'h9; dmx_code = 4'h8; end
            5'd8: begin slot_addr = 8'h43; src_code = 4'h9; dmx_code = 4'h9; end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  // Bus phase: address for cont_32 0-15, data (or released bus on reads) for 16-31.
  always_comb begin
    data_phase = cont_32[4];
    read_now   = active && data_phase && LE && (dmx_code != 4'h0);
    mux_sel    = 4'hF;
    demux_sel  = 4'h0;
    dato_out   = 8'h00;
    if (active) begin
      if (!data_phase) begin
        mux_sel  = 4'h0;
        dato_out = slot_addr;
      end else if (read_now) begin
        demux_sel = dmx_code;
      end else begin
        mux_sel = src_code;
        case (src_code)
          4'h1:    dato_out = Inicie;
          4'h2:    dato_out = Mod_S;
          4'h3:    dato_out = OUT_segh;
          4'h4:    dato_out = OUT_minh;
          4'h5:    dato_out = OUT_horah;
          4'h6:    dato_out = OUT_diaf;
          4'h7:    dato_out = OUT_mesf;
          4'h8:    dato_out = OUT_anof;
          default: dato_out = 8'h00;
        endcase
      end
    end
  end

  assign READ            = read_now;
  assign Selec_Mux_DDw   = mux_sel;
  assign Selec_Demux_DDw = demux_sel;
  assign DIR_DATO        = read_now ? 8'hzz : dato_out;

  always_comb begin
    cmd_d  = cmd_q;
    busy_d = busy_q;
    in_d   = in_q;
    if (busy_q && enable_cont_32 && (!burst || cont17 == 5'd16)) busy_d = 1'b0;
    // A new load wins over the end-of-transaction clear so it restarts cleanly.
    if (en_01 && port_id == CMD_PORT) begin
      cmd_d  = out_port;
      busy_d = 1'b1;
    end
    if (read_now && cont_32 == CAP_CNT) begin
      for (int i = 0; i < 9; i++) begin
        if (dmx_code == 4'(i + 1)) in_d[i] = DIR_DATO;
      end
    end
  end

  always_ff @(posedge reloj) begin
    if (resetM) begin
      cmd_q  <= 8'h00;
      busy_q <= 1'b0;
      in_q   <= '0;
    end else begin
      cmd_q  <= cmd_d;
      busy_q <= busy_d;
      in_q   <= in_d;
    end
  end

  assign IN_segh   = in_q[0];
  assign IN_minh   = in_q[1];
  assign IN_horah  = in_q[2];
  assign IN_diaf   = in_q[3];
  assign IN_mesf   = in_q[4];
  assign IN_anof   = in_q[5];
  assign IN_segcr  = in_q[6];
  assign IN_mincr  = in_q[7];
  assign IN_horacr = in_q[8];

endmodule

// File: tb/tb_mux_dir_dato.sv
// Directed bench for mux_dir_dato: single writes, single read, write/read bursts, wrong port.
module tb_mux_dir_dato;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_m;
  logic [7:0] inicie, mod_s, out_diaf, out_mesf, out_anof, out_segh, out_minh, out_horah;
  logic       en_01;
  logic [7:0] out_port, port_id;
  logic [4:0] cont_32, cont17;
  logic       enable_cont_32, le, sync;
  logic [7:0] in_diaf, in_mesf, in_anof, in_segh, in_minh, in_horah, in_segcr, in_mincr, in_horacr;
  logic [3:0] selec_demux, selec_mux;
  logic       read;
  wire  [7:0] dir_dato;
  logic       tb_drive;
  logic [7:0] tb_bus;

  assign dir_dato = tb_drive ? tb_bus : 8'hzz;

  logic [7:0] in_obs [9];
  assign in_obs[0] = in_segh;
  assign in_obs[1] = in_minh;
  assign in_obs[2] = in_horah;
  assign in_obs[3] = in_diaf;
  assign in_obs[4] = in_mesf;
  assign in_obs[5] = in_anof;
  assign in_obs[6] = in_segcr;
  assign in_obs[7] = in_mincr;
  assign in_obs[8] = in_horacr;

  logic [7:0] t_addr [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
  logic [7:0] t_data [9] = '{8'h06, 8'h07, 8'h08, 8'h03, 8'h04, 8'h05, 8'h00, 8'h00, 8'h00};
  logic [3:0] t_mux  [9] = '{4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'h9, 4'h9};

  int total = 0;
  int bad   = 0;

  mux_dir_dato dut (
    .reloj(clk), .resetM(reset_m),
    .Inicie(inicie), .Mod_S(mod_s),
    .OUT_diaf(out_diaf), .OUT_mesf(out_mesf), .OUT_anof(out_anof),
    .OUT_segh(out_segh), .OUT_minh(out_minh), .OUT_horah(out_horah),
    .en_01(en_01), .out_port(out_port), .port_id(port_id),
    .cont_32(cont_32), .enable_cont_32(enable_cont_32), .cont17(cont17),
    .LE(le), .sync(sync),
    .IN_diaf(in_diaf), .IN_mesf(in_mesf), .IN_anof(in_anof),
    .IN_segh(in_segh), .IN_minh(in_minh), .IN_horah(in_horah),
    .IN_segcr(in_segcr), .IN_mincr(in_mincr), .IN_horacr(in_horacr),
    .Selec_Demux_DDw(selec_demux), .READ(read), .Selec_Mux_DDw(selec_mux),
    .DIR_DATO(dir_dato)
  );

  // One clock of counter stimulus; outputs are sampled 2 time units after the edge.
  task automatic drive_cycle(input logic [4:0] c32, input logic [4:0] c17, input logic end_p,
                             input logic sy, input logic drv, input logic [7:0] val);
    @(posedge clk); #1;
    cont_32 = c32; cont17 = c17; enable_cont_32 = end_p; sync = sy;
    tb_drive = drv; tb_bus = val;
    #1;
  endtask

  task automatic load_cmd(input logic [7:0] c, input logic [7:0] pid);
    @(posedge clk); #1;
    en_01 = 1'b1; port_id = pid; out_port = c;
    cont_32 = 5'd0; cont17 = 5'd0; enable_cont_32 = 1'b0; tb_drive = 1'b0;
    @(posedge clk); #1;
    en_01 = 1'b0;
  endtask

  task automatic test_reset();
    reset_m = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_m = 1'b0;
    #1;
    for (int i = 0; i < 9; i++) begin
      total++;
      if (in_obs[i] !== 8'h00) begin bad++; $display("FAIL reset_in[%0d] got=%h exp=00", i, in_obs[i]); end
    end
    total++; if (read !== 1'b0) begin bad++; $display("FAIL reset_read got=%b exp=0", read); end
    total++; if (selec_mux !== 4'hF) begin bad++; $display("FAIL reset_mux got=%h exp=f", selec_mux); end
    total++; if (selec_demux !== 4'h0) begin bad++; $display("FAIL reset_demux got=%h exp=0", selec_demux); end
    total++; if (dir_dato !== 8'h00) begin bad++; $display("FAIL reset_bus got=%h exp=00", dir_dato); end
  endtask

  task automatic test_single_write(input logic [7:0] c, input logic [7:0] addr, input logic [7:0] data,
                                   input logic [3:0] mux, input logic le_v);
    logic [7:0] exp_d;
    logic [3:0] exp_m;
    le = le_v;
    load_cmd(c, 8'h10);
    for (int k = 0; k < 32; k++) begin
      drive_cycle(5'(k), 5'd0, 1'b0, k == 0, 1'b0, 8'h00);
      exp_d = (k < 16) ? addr : data;
      exp_m = (k < 16) ? 4'h0 : mux;
      total++; if (dir_dato !== exp_d) begin bad++; $display("FAIL wr%0h_bus k=%0d got=%h exp=%h", c, k, dir_dato, exp_d); end
      total++; if (selec_mux !== exp_m) begin bad++; $display("FAIL wr%0h_mux k=%0d got=%h exp=%h", c, k, selec_mux, exp_m); end
      total++; if (read !== 1'b0) begin bad++; $display("FAIL wr%0h_read k=%0d got=%b exp=0", c, k, read); end
    end
    drive_cycle(5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 8'h00);
    drive_cycle(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 8'h00);
    total++; if (selec_mux !== 4'hF) begin bad++; $display("FAIL wr%0h_idle_mux got=%h exp=f", c, selec_mux); end
    total++; if (dir_dato !== 8'h00) begin bad++; $display("FAIL wr%0h_idle_bus got=%h exp=00", c, dir_dato); end
  endtask

  task automatic test_read_single();
    logic drv;
    le = 1'b1;
    load_cmd(8'h01, 8'h10);
    for (int k = 0; k < 32; k++) begin
      drv = (k >= 16);
      drive_cycle(5'(k), 5'd0, 1'b0, k == 0, drv, 8'h21);
      if (k < 16) begin
        total++; if (dir_dato !== 8'h21) begin bad++; $display("FAIL rd_addr k=%0d got=%h exp=21", k, dir_dato); end
        total++; if (read !== 1'b0) begin bad++; $display("FAIL rd_addr_read k=%0d got=%b exp=0", k, read); end
        total++; if (selec_mux !== 4'h0) begin bad++; $display("FAIL rd_addr_mux k=%0d got=%h exp=0", k, selec_mux); end
      end else begin
        total++; if (read !== 1'b1) begin bad++; $display("FAIL rd_read k=%0d got=%b exp=1", k, read); end
        total++; if (selec_demux !== 4'h1) begin bad++; $display("FAIL rd_demux k=%0d got=%h exp=1", k, selec_demux); end
        total++; if (dir_dato !== 8'h21) begin bad++; $display("FAIL rd_bus k=%0d got=%h exp=21", k, dir_dato); end
      end
      if (k == 24) begin
        total++; if (in_segh !== 8'h00) begin bad++; $display("FAIL rd_precap got=%h exp=00", in_segh); end
      end
      if (k == 25) begin
        total++; if (in_segh !== 8'h21) begin bad++; $display("FAIL rd_cap got=%h exp=21", in_segh); end
      end
    end
    drive_cycle(5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 8'h00);
    drive_cycle(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 8'h00);
    total++; if (read !== 1'b0) begin bad++; $display("FAIL rd_idle_read got=%b exp=0", read); end
    total++; if (selec_mux !== 4'hF) begin bad++; $display("FAIL rd_idle_mux got=%h exp=f", selec_mux); end
    total++; if (in_minh !== 8'h00) begin bad++; $display("FAIL rd_other got=%h exp=00", in_minh); end
  endtask

  task automatic test_burst(input logic le_v);
    logic       rd;
    logic [7:0] exp_d, cap;
    logic [3:0] exp_m, exp_x;
    le = le_v;
    load_cmd(8'h02, 8'h10);
    for (int s = 0; s < 17; s++) begin
      cap = 8'h30 + 8'(s);
      for (int k = 0; k < 32; k++) begin
        rd = le_v && (s <= 8) && (k >= 16);
        drive_cycle(5'(k), 5'(s), 1'b0, (s == 0) && (k == 0), rd, cap);
        exp_x = 4'h0;
        if (k < 16) begin
          exp_d = (s <= 8) ? t_addr[s] : 8'h00;
          exp_m = 4'h0;
        end else if (rd) begin
          exp_d = cap;
          exp_m = 4'hF;
          exp_x = 4'(s + 1);
        end else begin
          exp_d = (s <= 8) ? t_data[s] : 8'h00;
          exp_m = (s <= 8) ? t_mux[s] : 4'hF;
        end
        total++; if (dir_dato !== exp_d) begin bad++; $display("FAIL burst%0b_bus s=%0d k=%0d got=%h exp=%h", le_v, s, k, dir_dato, exp_d); end
        total++; if (selec_mux !== exp_m) begin bad++; $display("FAIL burst%0b_mux s=%0d k=%0d got=%h exp=%h", le_v, s, k, selec_mux, exp_m); end
        total++; if (read !== rd) begin bad++; $display("FAIL burst%0b_read s=%0d k=%0d got=%b exp=%b", le_v, s, k, read, rd); end
        total++; if (selec_demux !== exp_x) begin bad++; $display("FAIL burst%0b_demux s=%0d k=%0d got=%h exp=%h", le_v, s, k, selec_demux, exp_x); end
        if (rd && k == 25) begin
          total++; if (in_obs[s] !== cap) begin bad++; $display("FAIL burst_cap s=%0d got=%h exp=%h", s, in_obs[s], cap); end
        end
      end
      drive_cycle(5'd0, 5'(s), 1'b1, 1'b0, 1'b0, 8'h00);
    end
    drive_cycle(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 8'h00);
    total++; if (selec_mux !== 4'hF) begin bad++; $display("FAIL burst%0b_end_mux got=%h exp=f", le_v, selec_mux); end
    total++; if (dir_dato !== 8'h00) begin bad++; $display("FAIL burst%0b_end_bus got=%h exp=00", le_v, dir_dato); end
  endtask

  task automatic test_bad_port();
    le = 1'b0;
    load_cmd(8'h02, 8'h11);
    for (int k = 0; k < 32; k += 5) begin
      drive_cycle(5'(k), 5'd0, 1'b0, k == 0, 1'b0, 8'h00);
      total++; if (selec_mux !== 4'hF) begin bad++; $display("FAIL badport_mux k=%0d got=%h exp=f", k, selec_mux); end
      total++; if (dir_dato !== 8'h00) begin bad++; $display("FAIL badport_bus k=%0d got=%h exp=00", k, dir_dato); end
      total++; if (read !== 1'b0) begin bad++; $display("FAIL badport_read k=%0d got=%b exp=0", k, read); end
    end
    total++; if (in_segh !== 8'h30) begin bad++; $display("FAIL badport_hold got=%h exp=30", in_segh); end
  endtask

  initial begin
    reset_m = 1'b1;
    inicie = 8'h01; mod_s = 8'h02;
    out_segh = 8'h06; out_minh = 8'h07; out_horah = 8'h08;
    out_diaf = 8'h03; out_mesf = 8'h04; out_anof = 8'h05;
    en_01 = 1'b0; out_port = 8'h00; port_id = 8'h00;
    cont_32 = 5'd0; cont17 = 5'd0; enable_cont_32 = 1'b0; le = 1'b0; sync = 1'b0;
    tb_drive = 1'b0; tb_bus = 8'h00;

    test_reset();
    test_single_write(8'h00, 8'h00, 8'h01, 4'h1, 1'b0);
    test_single_write(8'h03, 8'h01, 8'h02, 4'h2, 1'b0);
    test_single_write(8'h01, 8'h21, 8'h06, 4'h3, 1'b0);
    test_single_write(8'h00, 8'h00, 8'h01, 4'h1, 1'b1);
    test_read_single();
    test_burst(1'b0);
    test_burst(1'b1);
    test_bad_port();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_dir_dato.md
Name: mux_dir_dato

Overview:
- Bus multiplexer/demultiplexer between the PicoBlaze control path and the RTC's shared 8-bit address/data bus DIR_DATO.
- Latches a command from the PicoBlaze and frames one 32-clock byte transaction per cont_32 period: address phase, then data phase.
- Write transactions drive register contents onto DIR_DATO. Read transactions release the bus and capture the returned byte into the matching IN_* register.
- Sits between the PicoBlaze port logic and the RTC pin driver; the cont_32/cont17 sequencing counters come from the control path.

Parameters:
- CMD_PORT, 8'h10, port_id that loads the command register.
- CAP_CNT, 5'd24, cont_32 value at which read data is sampled.

Ports:
- reloj  in  1  system clock; everything samples on the rising edge.
- resetM  in  1  synchronous, active-high reset.
- Inicie, Mod_S  in  8 each  init/mode bytes for the single-write commands.
- OUT_diaf, OUT_mesf, OUT_anof, OUT_segh, OUT_minh, OUT_horah  in  8 each  date/time bytes to write.
- en_01  in  1  PicoBlaze write strobe.
- out_port  in  8  PicoBlaze write data.
- port_id  in  8  PicoBlaze port address.
- cont_32  in  5  position (0–31) inside the current byte transaction.
- enable_cont_32  in  1  one-clock pulse after cont_32==31 (end of transaction).
- cont17  in  5  slot index 0–16 within a burst.
- LE  in  1  1 = read, 0 = write.
- sync  in  1  transaction start; zeroes cont_32/cont17 externally.
- IN_diaf, IN_mesf, IN_anof, IN_segh, IN_minh, IN_horah  out  8 each  captured date/time.
- IN_segcr, IN_mincr, IN_horacr  out  8 each  captured timer (cronómetro) values.
- Selec_Demux_DDw  out  4  capture-target code.
- READ  out  1  high while the bus is released for a read.
- Selec_Mux_DDw  out  4  drive-source code.
- DIR_DATO  inout  8  RTC address/data bus.

Behaviour:
- Reset (synchronous, resetM=1 at a rising edge): cmd=8'h00, busy=0, all IN_* = 8'h00.
  - READ=0, Selec_Mux_DDw=4'hF, Selec_Demux_DDw=4'h0, DIR_DATO driven 8'h00.
- Command load: at a rising edge with en_01=1 and port_id==CMD_PORT, cmd<=out_port and busy<=1.
  - A load while busy restarts the sequence with the new command.
- Single commands end busy at the first enable_cont_32 after load:
  - cmd 00 = write Inicie to address 8'h00.
  - cmd 03 = write Mod_S to address 8'h01.
  - cmd 01 = LE=1: read address 8'h21 into IN_segh; LE=0: write OUT_segh to 8'h21.
- Burst, cmd 02: slot = cont17. busy clears at enable_cont_32 when cont17==16.
  - Slots 0–5: addresses 21–26 (seg, min, hora, dia, mes, ano).
  - Slots 6–8: addresses 41–43 (segcr, mincr, horacr).
  - Slots 9–16: dummy, address 00, no drive data, no capture.
- Any other cmd value: treated as idle.
- Phases (combinational from cont_32):
  - cont_32 0–15: address phase. DIR_DATO = slot address, Selec_Mux=0.
  - cont_32 16–31: data phase.
- Write data phase: DIR_DATO = selected byte. Slots 6–8 drive 8'h00.
- Selec_Mux codes: 1 Inicie, 2 Mod_S, 3 segh, 4 minh, 5 horah, 6 diaf, 7 mesf, 8 anof, 9 zero, F idle.
- Read data phase (LE=1, read-capable slot):
  - READ=1 and DIR_DATO=Z.
  - Selec_Demux codes: 1 segh, 2 minh, 3 horah, 4 diaf, 5 mesf, 6 anof, 7 segcr, 8 mincr, 9 horacr.
  - At the edge where cont_32==CAP_CNT, the selected IN_* register loads DIR_DATO (one-clock latency); others hold.
- Idle or dummy slot: READ=0, Selec_Demux=0. Idle drives 8'h00, Selec_Mux=F.
- LE is sampled every cycle; a change mid-burst applies from the next cycle.
- Bus is never driven while READ=1; IN_* change only at capture edges.

Test Plan:
- Reset, then release: all IN_*=00, READ=0, Selec_Mux=F, DIR_DATO=00.
- cmd 00 with sync: DIR_DATO=00 for cont_32 0–15, then 01 (Inicie) for 16–31; READ stays 0; idle after enable_cont_32.
- cmd 03, LE=0: address 01, then data 02 (Mod_S).
- cmd 01, LE=1, tb drives 8'h21 during cont_32 16–31:
  - Address 21 is driven first.
  - READ=1 with bus Z during the data phase.
  - IN_segh=21 one clock after cont_32==24.
- cmd 02, LE=0, 17 slots:
  - Data 06,07,08,03,04,05 on slots 0–5; 00 on slots 6–8; busy clears after slot 16.
  - Repeat with LE=1: READ pulses only on slots 0–8.
- port_id≠10 with en_01=1: cmd unchanged, no transaction.
